mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Sequences and shares the single-port 512x12 Simplez main memory between two requesters: port 0 (CPU) and port 1 (loader/monitor, which writes programs and inspects memory).
- Accepts one access at a time and drives the memory's address, read-enable and write-enable lines.
- Returns read data and a one-cycle ack to the winning requester.
- Sits between the CPU/loader and the memory block, which reads on the falling clock edge.

Parameters:
- AW, 9, address width (512 words)
- DW, 12, data width
- RD_LAT, 0, extra rising-edge cycles after ISSUE before mem_rdata is valid; 0 for the negedge-read memory, up to 3 allowed

Ports:
- clk  in  1  system clock, all logic on the rising edge
- rst  in  1  synchronous, active-high reset
- req0 / req1  in  1  access request, held high until ack
- we0 / we1  in  1  1 = write, 0 = read; stable while req is high
- addr0 / addr1  in  AW  word address
- wdata0 / wdata1  in  DW  write data
- ack0 / ack1  out  1  one-cycle completion pulse
- rdata0 / rdata1  out  DW  registered read data, valid while ack is high and held afterwards
- mem_addr  out  AW  memory address
- mem_re  out  1  memory read enable
- mem_we  out  1  memory write enable
- mem_wdata  out  DW  memory write data
- mem_rdata  in  DW  memory read data

Behaviour:
- One clock domain. Reset is synchronous and active-high on rst; clock is clk.
- Reset values:
  - state = IDLE
  - ack0, ack1, mem_re, mem_we = 0
  - mem_addr, mem_wdata, rdata0, rdata1 = 0
  - last_grant = 1, so port 0 wins the first tie
- States: IDLE -> ISSUE -> WAIT (RD_LAT cycles; skipped when RD_LAT = 0 or on a write) -> ACK -> IDLE.
- IDLE:
  - Requests are sampled only in IDLE.
  - If exactly one req is high, that port wins.
  - If both are high, the port not equal to last_grant wins.
  - The winner's addr, we and wdata are latched into mem_addr, mem_we (as we_q) and mem_wdata, and gnt_q is recorded. Next state is ISSUE.
  - No req: stay in IDLE.
- ISSUE (exactly 1 cycle):
  - mem_re = ~we_q and mem_we = we_q; both are registered, asserted only in this state, and never both high.
  - mem_addr and mem_wdata stay stable from ISSUE through ACK.
  - If RD_LAT = 0, mem_rdata is captured into rdata[gnt_q] at the end of ISSUE.
- WAIT (reads only): a down-counter runs RD_LAT cycles. mem_rdata is captured into rdata[gnt_q] at the end of the last WAIT cycle.
- ACK (exactly 1 cycle):
  - ack[gnt_q] = 1; last_grant <= gnt_q.
  - The requester must drop req, or present a new request, by the next IDLE cycle.
  - Because req is not sampled in ACK, a req still high during ACK is never double-accepted.
- Latency:
  - Read, RD_LAT = 0: req sampled at edge t, ack high in cycle t+2, 3 cycles per access.
  - Write: 3 cycles per access.
  - Read with RD_LAT = n: 3+n cycles.
- Only the granted port's rdata changes; the other port's rdata holds its previous value.
- Changes to req, addr or we on the losing port during an access are ignored until the next IDLE.
- A write to any address, including 511 (9'o777), is legal. There is no wrap logic; the address is passed through unchanged.
- Fairness: under continuous requests from both ports, grants strictly alternate 0, 1, 0, 1.
- Reset mid-operation:
  - On the first rising edge with rst = 1, state returns to IDLE and all strobes and acks drop to 0.
  - A write whose ISSUE cycle contains the memory's falling edge still completes in memory.
  - The aborted requester receives no ack and must re-request after reset.
- Simultaneous events:
  - If a req rises during ACK for the other port, it is served on the next IDLE cycle.
  - A port re-requesting in IDLE while the other port also requests loses to it, because last_grant points at itself.

Decomposition:
- Shared package simplez_pkg:
  - AW/DW constants
  - state encoding (IDLE, ISSUE, WAIT, ACK, 2 bits)
  - port ID constants (PORT_CPU = 0, PORT_MON = 1)
- One natural sub-module, rr_arb2: a 2-way round-robin picker.
  - Inputs: req0, req1, last_grant.
  - Outputs: gnt_valid, gnt_id.
  - Purely combinational; the FSM and datapath registers stay in mem_arbiter.

Test Plan:
1. Reset then single read: memory preloaded with word 2 = 12'o0002; req0 = 1, we0 = 0, addr0 = 2 -> mem_re high for exactly 1 cycle with mem_addr = 2; ack0 in the 3rd cycle after acceptance; rdata0 = 12'o0002; ack1 and rdata1 stay 0.
2. Loader write then CPU read: port 1 writes 12'o7000 to address 1 -> mem_we one cycle, ack1; then port 0 reads address 1 -> rdata0 = 12'o7000.
3. Contention: req0 and req1 both held high for 12 cycles, reads of addr 3 and addr 4 -> acks ordered 0, 1, 0, 1, each 3 cycles apart; first grant goes to port 0.
4. Boundary address: port 1 writes 12'o1234 to 9'o777, port 0 reads 9'o777 -> 12'o1234; address 0 is unchanged.
5. Reset mid-read: assert rst during ISSUE of a port-0 read -> next cycle state = IDLE, mem_re = 0, no ack0; after reset release a held req0 is re-accepted and acked normally.
6. RD_LAT = 2 build: single read -> ack0 five cycles after acceptance; rdata0 matches memory; mem_re high only in the ISSUE cycle.

Source files
------------

// File: rtl/mem_arbiter_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : simplez_pkg
//  Purpose  : Shared constants for the Simplez memory arbiter: memory geometry,
//             arbiter FSM state encoding and requester port identifiers.
//  Revision : 1.0 - initial release
// ============================================================================
package simplez_pkg;

    // Simplez main memory geometry: 512 words of 12 bits.
    localparam int MEM_AW = 9;
    localparam int MEM_DW = 12;

    // Arbiter FSM state encoding.
    typedef logic [1:0] state_t;
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ISSUE = 2'd1;
    localparam logic [1:0] ST_WAIT  = 2'd2;
    localparam logic [1:0] ST_ACK   = 2'd3;

    // Requester identifiers.
    localparam logic PORT_CPU = 1'b0;
    localparam logic PORT_MON = 1'b1;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter_if
//  Purpose  : Bundles both requester handshakes (CPU port 0, loader/monitor
//             port 1) and the single-port memory bus seen by the arbiter.
//  Ports    : req/we/addr/wdata per requester (towards arbiter),
//             ack/rdata per requester (from arbiter),
//             mem_addr/mem_re/mem_we/mem_wdata (from arbiter), mem_rdata (to it)
//  Modports : slave  - the arbiter
//             master - requesters and memory (the surrounding system)
//  Revision : 1.0 - initial release
// ============================================================================
interface mem_arbiter_if
    import simplez_pkg::*;
#(
    parameter int AW = MEM_AW,
    parameter int DW = MEM_DW
) ();

    logic          req0;
    logic          req1;
    logic          we0;
    logic          we1;
    logic [AW-1:0] addr0;
    logic [AW-1:0] addr1;
    logic [DW-1:0] wdata0;
    logic [DW-1:0] wdata1;
    logic          ack0;
    logic          ack1;
    logic [DW-1:0] rdata0;
    logic [DW-1:0] rdata1;

    logic [AW-1:0] mem_addr;
    logic          mem_re;
    logic          mem_we;
    logic [DW-1:0] mem_wdata;
    logic [DW-1:0] mem_rdata;

    modport slave (
        input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        output ack0, ack1, rdata0, rdata1, mem_addr, mem_re, mem_we, mem_wdata
    );

    modport master (
        output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, mem_rdata,
        input  ack0, ack1, rdata0, rdata1, mem_addr, mem_re, mem_we, mem_wdata
    );

endinterface
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Purpose  : Two-way round-robin picker (purely combinational).
//  Ports    : req0, req1   - pending requests
//             last_grant   - port that won the previous access
//             gnt_valid    - at least one request pending
//             gnt_id       - winning port (0 = CPU, 1 = monitor)
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import simplez_pkg::*;
(
    input  logic req0,
    input  logic req1,
    input  logic last_grant,
    output logic gnt_valid,
    output logic gnt_id
);

    assign gnt_valid = req0 | req1;

    // On a tie the port that did not win last time gets the memory.
    always_comb begin
        gnt_id = PORT_CPU;
        if (req0 && req1) begin
            gnt_id = ~last_grant;
        end else if (req1) begin
            gnt_id = PORT_MON;
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Purpose  : Shares the single-port 512x12 Simplez memory between the CPU
//             (port 0) and the loader/monitor (port 1). One access at a time:
//             IDLE -> ISSUE -> [WAIT x RD_LAT, reads only] -> ACK -> IDLE.
//  Ports    : clk  - system clock, rising edge
//             rst  - synchronous active-high reset
//             bus  - mem_arbiter_if.slave (requester handshakes + memory bus)
//  Params   : AW, DW  - address / data width
//             RD_LAT  - extra cycles after ISSUE until mem_rdata is valid (0..3)
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import simplez_pkg::*;
#(
    parameter int AW     = MEM_AW,
    parameter int DW     = MEM_DW,
    parameter int RD_LAT = 0
) (
    input  logic         clk,
    input  logic         rst,
    mem_arbiter_if.slave bus
);

    // Loaded into the wait counter on leaving ISSUE; WAIT lasts RD_LAT cycles.
    localparam logic [1:0] WAIT_INIT = 2'(RD_LAT - 1);
    localparam bit         NO_WAIT   = (RD_LAT == 0);

    logic [1:0]    state;
    logic [1:0]    wait_cnt;
    logic          last_grant;
    logic          gnt_q;
    logic          we_q;
    logic          ack0_q;
    logic          ack1_q;
    logic          mem_re_q;
    logic          mem_we_q;
    logic [AW-1:0] addr_q;
    logic [DW-1:0] wdata_q;
    logic [DW-1:0] rdata0_q;
    logic [DW-1:0] rdata1_q;

    logic          gnt_valid;
    logic          gnt_id;
    logic          win_we;
    logic [AW-1:0] win_addr;
    logic [DW-1:0] win_wdata;

    rr_arb2 u_rr_arb2 (
        .req0       (bus.req0),
        .req1       (bus.req1),
        .last_grant (last_grant),
        .gnt_valid  (gnt_valid),
        .gnt_id     (gnt_id)
    );

    // Request fields of the winning port.
    always_comb begin
        win_we    = bus.we0;
        win_addr  = bus.addr0;
        win_wdata = bus.wdata0;
        if (gnt_id == PORT_MON) begin
            win_we    = bus.we1;
            win_addr  = bus.addr1;
            win_wdata = bus.wdata1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= ST_IDLE;
            wait_cnt   <= 2'd0;
            last_grant <= PORT_MON;
            gnt_q      <= PORT_CPU;
            we_q       <= 1'b0;
            ack0_q     <= 1'b0;
            ack1_q     <= 1'b0;
            mem_re_q   <= 1'b0;
            mem_we_q   <= 1'b0;
            addr_q     <= '0;
            wdata_q    <= '0;
            rdata0_q   <= '0;
            rdata1_q   <= '0;
        end else begin
            // Strobes and acks are single-cycle pulses by default.
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            mem_re_q <= 1'b0;
            mem_we_q <= 1'b0;

            case (state)
                ST_IDLE: begin
                    if (gnt_valid) begin
                        gnt_q    <= gnt_id;
                        we_q     <= win_we;
                        addr_q   <= win_addr;
                        wdata_q  <= win_wdata;
                        // Registered here so they are high exactly during ISSUE.
                        mem_re_q <= ~win_we;
                        mem_we_q <= win_we;
                        state    <= ST_ISSUE;
                    end
                end

                ST_ISSUE: begin
                    if (we_q || NO_WAIT) begin
                        if (!we_q) begin
                            if (gnt_q == PORT_MON) rdata1_q <= bus.mem_rdata;
                            else                   rdata0_q <= bus.mem_rdata;
                        end
                        if (gnt_q == PORT_MON) ack1_q <= 1'b1;
                        else                   ack0_q <= 1'b1;
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= WAIT_INIT;
                        state    <= ST_WAIT;
                    end
                end

                ST_WAIT: begin
                    if (wait_cnt == 2'd0) begin
                        if (gnt_q == PORT_MON) begin
                            rdata1_q <= bus.mem_rdata;
                            ack1_q   <= 1'b1;
                        end else begin
                            rdata0_q <= bus.mem_rdata;
                            ack0_q   <= 1'b1;
                        end
                        state <= ST_ACK;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end

                ST_ACK: begin
                    // Requests are not looked at here, so a req still held
                    // during its own ack cannot be accepted twice.
                    last_grant <= gnt_q;
                    state      <= ST_IDLE;
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.ack0      = ack0_q;
    assign bus.ack1      = ack1_q;
    assign bus.rdata0    = rdata0_q;
    assign bus.rdata1    = rdata1_q;
    assign bus.mem_addr  = addr_q;
    assign bus.mem_re    = mem_re_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_wdata = wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Purpose  : Self-checking bench for mem_arbiter. Instance A uses RD_LAT = 0
//             with a negedge-read memory; instance B uses RD_LAT = 2 with a
//             memory whose read data only becomes valid two cycles late.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;
    import simplez_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    mem_arbiter_if bus_a ();
    mem_arbiter_if bus_b ();

    mem_arbiter #(.RD_LAT(0)) u_dut_a (.clk(clk), .rst(rst), .bus(bus_a.slave));
    mem_arbiter #(.RD_LAT(2)) u_dut_b (.clk(clk), .rst(rst), .bus(bus_b.slave));

    logic [11:0] mem_a [512];
    logic [11:0] mem_b [512];
    int          dly_b;

    // Memory A: reads and writes on the falling edge.
    always @(negedge clk) begin
        if (bus_a.mem_we) mem_a[bus_a.mem_addr] <= bus_a.mem_wdata;
        if (bus_a.mem_re) bus_a.mem_rdata <= mem_a[bus_a.mem_addr];
    end

    // Memory B: read data is junk until two falling edges after the strobe.
    always @(negedge clk) begin
        if (bus_b.mem_we) mem_b[bus_b.mem_addr] <= bus_b.mem_wdata;
        if (bus_b.mem_re) begin
            bus_b.mem_rdata <= 12'o6666;
            dly_b           <= 2;
        end else if (dly_b != 0) begin
            dly_b <= dly_b - 1;
            if (dly_b == 1) bus_b.mem_rdata <= mem_b[bus_b.mem_addr];
        end
    end

    int checks   = 0;
    int failures = 0;

    // Expected rdata per [instance][port].
    logic [11:0] mdl [2][2];

    typedef struct {
        logic        port;
        logic        we;
        logic [8:0]  addr;
        logic [11:0] wdata;
        logic [11:0] exp_rd;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int s = 0; s < 2; s++) for (int p = 0; p < 2; p++) mdl[s][p] = 12'd0;
    endtask

    task automatic drive(input bit sel, input logic port, input logic req, input logic we,
                         input logic [8:0] addr, input logic [11:0] wdata);
        if (!sel && !port) begin
            bus_a.req0 = req; bus_a.we0 = we; bus_a.addr0 = addr; bus_a.wdata0 = wdata;
        end else if (!sel) begin
            bus_a.req1 = req; bus_a.we1 = we; bus_a.addr1 = addr; bus_a.wdata1 = wdata;
        end else if (!port) begin
            bus_b.req0 = req; bus_b.we0 = we; bus_b.addr0 = addr; bus_b.wdata0 = wdata;
        end else begin
            bus_b.req1 = req; bus_b.we1 = we; bus_b.addr1 = addr; bus_b.wdata1 = wdata;
        end
    endtask

    // One complete access on instance sel; called #1 after a rising edge in IDLE.
    task automatic access(input bit sel, input logic port, input logic we, input logic [8:0] addr,
                          input logic [11:0] wdata, input logic [11:0] exp_rd,
                          input int exp_lat, input string tag);
        int   lat = 0, strobes = 0, wrong = 0, both = 0, scyc = 0;
        logic [8:0] saddr = '0;
        logic swe = 1'b0;
        logic re_s, we_s, my_ack, other_ack;
        drive(sel, port, 1'b1, we, addr, wdata);
        for (int c = 1; c <= 12 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            re_s      = sel ? bus_b.mem_re : bus_a.mem_re;
            we_s      = sel ? bus_b.mem_we : bus_a.mem_we;
            my_ack    = sel ? (port ? bus_b.ack1 : bus_b.ack0) : (port ? bus_a.ack1 : bus_a.ack0);
            other_ack = sel ? (port ? bus_b.ack0 : bus_b.ack1) : (port ? bus_a.ack0 : bus_a.ack1);
            if (re_s || we_s) begin
                strobes++;
                scyc  = c;
                saddr = sel ? bus_b.mem_addr : bus_a.mem_addr;
                swe   = we_s;
                if (re_s && we_s) both++;
            end
            if (other_ack) wrong++;
            if (my_ack) lat = c;
        end
        drive(sel, port, 1'b0, 1'b0, 9'd0, 12'd0);
        if (!we) mdl[sel][port] = exp_rd;
        check({tag, " ack latency"}, lat, exp_lat);
        check({tag, " strobe count"}, strobes, 1);
        check({tag, " strobe cycle"}, scyc, 1);
        check({tag, " strobe addr"}, saddr, addr);
        check({tag, " strobe is write"}, swe, we);
        check({tag, " re and we together"}, both, 0);
        check({tag, " other port ack"}, wrong, 0);
        check({tag, " rdata0"}, sel ? bus_b.rdata0 : bus_a.rdata0, mdl[sel][0]);
        check({tag, " rdata1"}, sel ? bus_b.rdata1 : bus_a.rdata1, mdl[sel][1]);
        @(posedge clk);
        #1;
    endtask

    int ack_id [8];
    int ack_cyc[8];
    int n_ack;
    int lat;

    initial begin
        for (int i = 0; i < 512; i++) begin
            mem_a[i] = 12'(i);
            mem_b[i] = 12'(i);
        end
        dly_b = 0;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
        drive(1'b1, 1'b1, 1'b0, 1'b0, 9'd0, 12'd0);

        //        port we    addr     wdata    exp_rd
        vecs[0] = '{1'b0, 1'b0, 9'd2,   12'd0,   12'o0002};
        vecs[1] = '{1'b1, 1'b1, 9'd1,   12'o7000, 12'd0};
        vecs[2] = '{1'b0, 1'b0, 9'd1,   12'd0,   12'o7000};
        vecs[3] = '{1'b1, 1'b1, 9'o777, 12'o1234, 12'd0};
        vecs[4] = '{1'b0, 1'b0, 9'o777, 12'd0,   12'o1234};
        vecs[5] = '{1'b0, 1'b0, 9'd0,   12'd0,   12'o0000};
        vecs[6] = '{1'b1, 1'b0, 9'd3,   12'd0,   12'o0003};
        vecs[7] = '{1'b0, 1'b1, 9'd6,   12'o4321, 12'd0};
        vecs[8] = '{1'b1, 1'b0, 9'd6,   12'd0,   12'o4321};

        do_reset();
        check("reset ack0", bus_a.ack0, 0);
        check("reset ack1", bus_a.ack1, 0);
        check("reset mem_re", bus_a.mem_re, 0);
        check("reset mem_we", bus_a.mem_we, 0);
        check("reset mem_addr", bus_a.mem_addr, 0);
        check("reset mem_wdata", bus_a.mem_wdata, 0);
        check("reset rdata0", bus_a.rdata0, 0);
        check("reset rdata1", bus_a.rdata1, 0);

        for (int i = 0; i < 9; i++) begin
            access(1'b0, vecs[i].port, vecs[i].we, vecs[i].addr, vecs[i].wdata,
                   vecs[i].exp_rd, 2, $sformatf("vec%0d", i));
        end
        check("mem 777 written", mem_a[9'o777], 12'o1234);
        check("mem 0 untouched", mem_a[0], 12'o0000);

        // Contention: both ports hold read requests for 12 cycles.
        do_reset();
        for (int i = 0; i < 8; i++) begin ack_id[i] = 99; ack_cyc[i] = 99; end
        n_ack = 0;
        drive(1'b0, 1'b0, 1'b1, 1'b0, 9'd3, 12'd0);
        drive(1'b0, 1'b1, 1'b1, 1'b0, 9'd4, 12'd0);
        for (int c = 1; c <= 12; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.ack0 && n_ack < 8) begin ack_id[n_ack] = 0; ack_cyc[n_ack] = c; n_ack++; end
            if (bus_a.ack1 && n_ack < 8) begin ack_id[n_ack] = 1; ack_cyc[n_ack] = c; n_ack++; end
        end
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 9'd0, 12'd0);
        check("contention ack count", n_ack, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("contention ack%0d port", i), ack_id[i], i % 2);
            check($sformatf("contention ack%0d cycle", i), ack_cyc[i], 2 + 3 * i);
        end
        check("contention rdata0", bus_a.rdata0, 12'o0003);
        check("contention rdata1", bus_a.rdata1, 12'o0004);
        @(posedge clk);
        #1;

        // Reset during ISSUE of a port-0 read; req0 stays high throughout.
        do_reset();
        drive(1'b0, 1'b0, 1'b1, 1'b0, 9'd2, 12'd0);
        @(posedge clk);
        #1;
        check("midreset issue mem_re", bus_a.mem_re, 1);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midreset mem_re dropped", bus_a.mem_re, 0);
        check("midreset no ack0", bus_a.ack0, 0);
        rst = 1'b0;
        lat = 0;
        for (int c = 1; c <= 10 && lat == 0; c++) begin
            @(posedge clk);
            #1;
            if (bus_a.ack0) lat = c;
        end
        check("midreset reaccept latency", lat, 2);
        check("midreset rdata0", bus_a.rdata0, 12'o0002);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 9'd0, 12'd0);
        @(posedge clk);
        #1;

        // RD_LAT = 2 instance: reads take two extra cycles, writes do not.
        access(1'b1, 1'b0, 1'b0, 9'd5, 12'd0, 12'o0005, 4, "lat2 read");
        access(1'b1, 1'b1, 1'b1, 9'd7, 12'o0707, 12'd0, 2, "lat2 write");
        access(1'b1, 1'b0, 1'b0, 9'd7, 12'd0, 12'o0707, 4, "lat2 readback");
        access(1'b1, 1'b1, 1'b0, 9'd8, 12'd0, 12'o0010, 4, "lat2 port1 read");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
